// File: rtl/slave_out_port_pkg.sv
// Shared definitions for the slave-side serial read-data port.
// Holds the FSM encoding, the default word width and the bit order used by master_in_port.
package slave_out_port_pkg;

   typedef enum logic [1:0] {
      IDLE           = 2'd0,
      WAIT_HANDSHAKE = 2'd1,
      SEND_DATA      = 2'd2
   } state_t;

   localparam int DEF_DATA_LEN = 8;

   // Both ends of the link must agree; master_in_port imports the same constant.
   localparam bit LSB_FIRST = 1'b1;

endpackage

// File: rtl/slave_out_shifter.sv
// Parallel-in serial-out shifter; tx_data is the registered current bit.
// clr has priority over load, which has priority over shift.
module slave_out_shifter
   import slave_out_port_pkg::*;
#(
   parameter int W = DEF_DATA_LEN
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] data_in,
   output logic         tx_data
);

   logic [W-1:0] sreg;
   logic [W-1:0] nxt;

   assign nxt = LSB_FIRST ? (sreg >> 1) : (sreg << 1);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         sreg    <= '0;
         tx_data <= 1'b0;
      end else if (load) begin
         sreg    <= data_in;
         tx_data <= LSB_FIRST ? data_in[0] : data_in[W-1];
      end else if (shift) begin
         sreg    <= nxt;
         tx_data <= LSB_FIRST ? nxt[0] : nxt[W-1];
      end
   end

endmodule

// File: rtl/slave_out_port.sv
// Slave-side serial transmitter: valid/ready handshake, then the word LSB-first on tx_data.
// Define SLAVE_OUT_HS_TIMEOUT_EN to add a handshake timeout with a tx_abort pulse.
module slave_out_port
   import slave_out_port_pkg::*;
#(
   parameter int DATA_LEN = DEF_DATA_LEN,
   parameter int TIMEOUT  = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                send_en,
   input  logic [DATA_LEN-1:0] data_in,
   input  logic                master_ready,
   output logic                slave_valid,
   output logic                tx_data,
   output logic                tx_done,
`ifdef SLAVE_OUT_HS_TIMEOUT_EN
   output logic                tx_abort,
`endif
   output logic                busy
);

   localparam int CW = $clog2(DATA_LEN + 1);

   if (DATA_LEN < 1) begin : g_bad_len
      $error("slave_out_port: DATA_LEN must be at least 1");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("slave_out_port: TIMEOUT must be at least 1");
   end

   state_t        state, state_n;
   logic [CW-1:0] count, count_n;
   logic          valid_n, busy_n, done_n;
   logic          ld, sh, clr;

`ifdef SLAVE_OUT_HS_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] wcnt, wcnt_n;
   logic          abort_n;
`endif

   slave_out_shifter #(.W(DATA_LEN)) u_shifter (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr),
      .load    (ld),
      .shift   (sh),
      .data_in (data_in),
      .tx_data (tx_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         count       <= '0;
         slave_valid <= 1'b0;
         busy        <= 1'b0;
         tx_done     <= 1'b0;
      end else begin
         state       <= state_n;
         count       <= count_n;
         slave_valid <= valid_n;
         busy        <= busy_n;
         tx_done     <= done_n;
      end
   end

`ifdef SLAVE_OUT_HS_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         wcnt     <= '0;
         tx_abort <= 1'b0;
      end else begin
         wcnt     <= wcnt_n;
         tx_abort <= abort_n;
      end
   end
`endif

   always_comb begin
      state_n = state;
      count_n = count;
      valid_n = slave_valid;
      busy_n  = busy;
      done_n  = 1'b0;
      ld      = 1'b0;
      sh      = 1'b0;
      clr     = 1'b0;
`ifdef SLAVE_OUT_HS_TIMEOUT_EN
      wcnt_n  = wcnt;
      abort_n = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (send_en) begin
               ld      = 1'b1;
               valid_n = 1'b1;
               busy_n  = 1'b1;
               count_n = CW'(1);
               state_n = WAIT_HANDSHAKE;
`ifdef SLAVE_OUT_HS_TIMEOUT_EN
               wcnt_n  = '0;
`endif
            end
         end
         WAIT_HANDSHAKE: begin
            // The master samples bit 0 on this edge, so bit 1 goes out next.
            if (slave_valid && master_ready) begin
               valid_n = 1'b0;
               if (DATA_LEN == 1) begin
                  clr     = 1'b1;
                  done_n  = 1'b1;
                  busy_n  = 1'b0;
                  count_n = '0;
                  state_n = IDLE;
               end else begin
                  sh      = 1'b1;
                  state_n = SEND_DATA;
               end
            end
`ifdef SLAVE_OUT_HS_TIMEOUT_EN
            else if (wcnt == TW'(TIMEOUT - 1)) begin
               clr     = 1'b1;
               abort_n = 1'b1;
               valid_n = 1'b0;
               busy_n  = 1'b0;
               count_n = '0;
               state_n = IDLE;
            end else begin
               wcnt_n = wcnt + 1'b1;
            end
`endif
         end
         SEND_DATA: begin
            // count tracks the index of the bit currently on tx_data.
            if (count == CW'(DATA_LEN - 1)) begin
               clr     = 1'b1;
               done_n  = 1'b1;
               busy_n  = 1'b0;
               count_n = '0;
               state_n = IDLE;
            end else begin
               sh      = 1'b1;
               count_n = count + 1'b1;
            end
         end
         default: begin
            clr     = 1'b1;
            valid_n = 1'b0;
            busy_n  = 1'b0;
            count_n = '0;
            state_n = IDLE;
         end
      endcase
   end

endmodule
